dmem_lsu: RTL and testbench

- RV32 data memory with a built-in load/store alignment unit for the single-cycle/multi-cycle core.
- Replaces the flat word-only data RAM and adds the following:
  - byte and halfword access with sign/zero extension;
  - byte-lane writes;
  - misaligned and out-of-range fault reporting;
  - a valid/ready request/response handshake with a configurable wait-state count.
- Sits between the core's memory stage and on-chip data storage.

---
 rtl/dmem_lsu.sv | 187 ++++++++++++++++++
 tb/tb_dmem_lsu.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_lsu.sv
// dmem_lsu: RV32 data memory with load/store alignment, fault detection and a
// valid/ready request/response handshake with a configurable wait-state count.
module dmem_lsu #(
  parameter int unsigned   DEPTH_WORDS = 1024,
  parameter int unsigned   AW          = 32,
  parameter logic [AW-1:0] BASE_ADDR   = '0,
  parameter int unsigned   WAIT_CYCLES = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [2:0]    req_funct3,
  input  logic [AW-1:0] req_addr,
  input  logic [31:0]   req_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [31:0]   rsp_rdata,
  output logic          rsp_err
);

  localparam int unsigned IDXW = $clog2(DEPTH_WORDS);
  localparam int unsigned CW   = 4;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  typedef struct packed {
    logic          we;
    logic [2:0]    funct3;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
  } req_t;

  logic [31:0]   mem [DEPTH_WORDS];

  state_t        state_q, state_n;
  logic [CW-1:0] cnt_q, cnt_n;
  req_t          req_q;
  req_t          src;
  logic          accept;
  logic          enter_resp;

  logic [AW-1:0]   off;
  logic [1:0]      lane;
  logic [IDXW-1:0] idx;
  logic            illegal, misalign, below, oor, err;
  logic [3:0]      be;
  logic [31:0]     wdata_rep;
  logic [31:0]     rd_word, shifted, load_val;

  // A handshake is only honoured outside reset, and only while ready is shown
  assign accept = req_valid & req_ready & ~rst;

  // In IDLE the live request is decoded (store commit / zero-wait load);
  // afterwards the captured copy is used
  always_comb begin
    src = req_q;
    if (state_q == IDLE) begin
      src = '{we: req_we, funct3: req_funct3, addr: req_addr, wdata: req_wdata};
    end
  end

  // Address, size and fault decode
  always_comb begin
    off      = src.addr - BASE_ADDR;
    lane     = off[1:0];
    idx      = off[IDXW+1:2];
    below    = src.addr < BASE_ADDR;
    oor      = (off >> (IDXW + 2)) != '0;
    illegal  = 1'b0;
    misalign = 1'b0;
    be        = 4'b0000;
    wdata_rep = src.wdata;
    case (src.funct3)
      3'b000: begin
        be        = 4'(4'b0001 << lane);
        wdata_rep = {4{src.wdata[7:0]}};
      end
      3'b001: begin
        misalign  = lane[0];
        be        = 4'(4'b0011 << lane);
        wdata_rep = {2{src.wdata[15:0]}};
      end
      3'b010: begin
        misalign = lane != 2'b00;
        be       = 4'b1111;
      end
      3'b100, 3'b101: illegal = src.we;
      default: illegal = 1'b1;
    endcase
    err = illegal | misalign | below | oor;
  end

  // Load extraction: shift the addressed lane down, then sign/zero extend
  always_comb begin
    rd_word  = mem[idx];
    shifted  = rd_word >> {lane, 3'b000};
    load_val = shifted;
    case (src.funct3[1:0])
      2'b00:   load_val = {{24{~src.funct3[2] & shifted[7]}}, shifted[7:0]};
      2'b01:   load_val = {{16{~src.funct3[2] & shifted[15]}}, shifted[15:0]};
      default: load_val = shifted;
    endcase
    if (src.we || err) begin
      load_val = 32'h0;
    end
  end

  // Next-state logic and wait-state counter
  always_comb begin
    state_n    = state_q;
    cnt_n      = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          cnt_n = '0;
          if (WAIT_CYCLES == 0) begin
            state_n = RESP;
          end else begin
            state_n = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_n = CW'(cnt_q + CW'(1));
        if (cnt_n == CW'(WAIT_CYCLES)) begin
          state_n = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    enter_resp = (state_n == RESP) && (state_q != RESP);
  end

  // State and counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
    end
  end

  // Request capture for use during WAIT/RESP
  always_ff @(posedge clk) begin
    if (accept) begin
      req_q <= src;
    end
  end

  // Byte-lane store commit on the acceptance edge; storage is never reset
  always_ff @(posedge clk) begin
    if (accept && src.we && !err) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) begin
          mem[idx][b*8 +: 8] <= wdata_rep[b*8 +: 8];
        end
      end
    end
  end

  // Registered handshake and response outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
    end else begin
      req_ready <= (state_n == IDLE);
      rsp_valid <= (state_n == RESP);
      if (enter_resp) begin
        rsp_rdata <= load_val;
        rsp_err   <= err;
      end
    end
  end

endmodule

// File: tb/tb_dmem_lsu.sv
// Scoreboard bench for dmem_lsu: three instances cover zero-wait, three-wait
// and non-zero base address configurations.
module tb_dmem_lsu;

  localparam int unsigned ND    = 3;
  localparam int unsigned DEPTH = 1024;
  localparam int unsigned WAITS [ND] = '{0, 3, 0};
  localparam logic [31:0] BASES [ND] = '{32'h0, 32'h0, 32'h8000_0000};

  localparam logic [2:0] F_B  = 3'b000;
  localparam logic [2:0] F_H  = 3'b001;
  localparam logic [2:0] F_W  = 3'b010;
  localparam logic [2:0] F_BU = 3'b100;
  localparam logic [2:0] F_HU = 3'b101;
  localparam logic [2:0] F_X  = 3'b011;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst        [ND];
  logic        req_valid  [ND];
  logic        req_ready  [ND];
  logic        req_we     [ND];
  logic [2:0]  req_funct3 [ND];
  logic [31:0] req_addr   [ND];
  logic [31:0] req_wdata  [ND];
  logic        rsp_valid  [ND];
  logic        rsp_ready  [ND];
  logic [31:0] rsp_rdata  [ND];
  logic        rsp_err    [ND];

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    dmem_lsu #(
      .DEPTH_WORDS(DEPTH),
      .AW(32),
      .BASE_ADDR(BASES[g]),
      .WAIT_CYCLES(WAITS[g])
    ) u_dut (
      .clk(clk),
      .rst(rst[g]),
      .req_valid(req_valid[g]),
      .req_ready(req_ready[g]),
      .req_we(req_we[g]),
      .req_funct3(req_funct3[g]),
      .req_addr(req_addr[g]),
      .req_wdata(req_wdata[g]),
      .rsp_valid(rsp_valid[g]),
      .rsp_ready(rsp_ready[g]),
      .rsp_rdata(rsp_rdata[g]),
      .rsp_err(rsp_err[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Issue one request on instance d, push its expected response, then
  // collect and compare the response; optionally stall rsp_ready for hold cycles.
  task automatic txn(input int d, input string tag, input logic we, input logic [2:0] f3,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [31:0] exp_rdata, input logic exp_err, input int hold);
    int   ta;
    int   n;
    exp_t e;
    @(negedge clk);
    req_we[d]     = we;
    req_funct3[d] = f3;
    req_addr[d]   = addr;
    req_wdata[d]  = wdata;
    req_valid[d]  = 1'b1;
    n = 0;
    while (!req_ready[d] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready[d]) begin
      check({tag, "_accept_timeout"}, 32'd0, 32'd1);
      req_valid[d] = 1'b0;
      return;
    end
    @(posedge clk);
    sb.push_back('{rdata: exp_rdata, err: exp_err});
    @(negedge clk);
    ta = cyc;
    req_valid[d] = 1'b0;
    if (hold > 0) rsp_ready[d] = 1'b0;
    n = 0;
    while (!rsp_valid[d] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!rsp_valid[d]) begin
      check({tag, "_rsp_timeout"}, 32'd0, 32'd1);
      rsp_ready[d] = 1'b1;
      return;
    end
    if (sb.size() == 0) begin
      check({tag, "_unexpected_rsp"}, 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    check({tag, "_rdata"}, rsp_rdata[d], e.rdata);
    check({tag, "_err"}, 32'(rsp_err[d]), 32'(e.err));
    check({tag, "_latency"}, 32'(cyc - ta), 32'(WAITS[d]));
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        check({tag, "_hold_valid"}, 32'(rsp_valid[d]), 32'd1);
        check({tag, "_hold_rdata"}, rsp_rdata[d], e.rdata);
        check({tag, "_hold_ready"}, 32'(req_ready[d]), 32'd0);
      end
      rsp_ready[d] = 1'b1;
      @(negedge clk);
      check({tag, "_release_valid"}, 32'(rsp_valid[d]), 32'd0);
      check({tag, "_release_ready"}, 32'(req_ready[d]), 32'd1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int seen;
    for (int d = 0; d < ND; d++) begin
      rst[d]        = 1'b1;
      req_valid[d]  = 1'b0;
      req_we[d]     = 1'b0;
      req_funct3[d] = 3'b000;
      req_addr[d]   = 32'h0;
      req_wdata[d]  = 32'h0;
      rsp_ready[d]  = 1'b1;
    end
    @(negedge clk);
    @(negedge clk);
    for (int d = 0; d < ND; d++) begin
      check("reset_req_ready", 32'(req_ready[d]), 32'd0);
      check("reset_rsp_valid", 32'(rsp_valid[d]), 32'd0);
      check("reset_rsp_rdata", rsp_rdata[d], 32'h0);
      check("reset_rsp_err", 32'(rsp_err[d]), 32'd0);
      rst[d] = 1'b0;
    end
    @(negedge clk);
    for (int d = 0; d < ND; d++) check("post_reset_ready", 32'(req_ready[d]), 32'd1);

    // Zero wait states, base 0
    txn(0, "sw_10",      1'b1, F_W,  32'h10,   32'hDEADBEEF, 32'h0,        1'b0, 0);
    txn(0, "lw_10",      1'b0, F_W,  32'h10,   32'h0,        32'hDEADBEEF, 1'b0, 0);
    txn(0, "sb_11",      1'b1, F_B,  32'h11,   32'h00000055, 32'h0,        1'b0, 0);
    txn(0, "lw_10_sb",   1'b0, F_W,  32'h10,   32'h0,        32'hDEAD55EF, 1'b0, 0);
    txn(0, "lb_13",      1'b0, F_B,  32'h13,   32'h0,        32'hFFFFFFDE, 1'b0, 0);
    txn(0, "lbu_13",     1'b0, F_BU, 32'h13,   32'h0,        32'h000000DE, 1'b0, 0);
    txn(0, "lh_12",      1'b0, F_H,  32'h12,   32'h0,        32'hFFFFDEAD, 1'b0, 0);
    txn(0, "lhu_10",     1'b0, F_HU, 32'h10,   32'h0,        32'h000055EF, 1'b0, 0);
    txn(0, "lw_mis",     1'b0, F_W,  32'h12,   32'h0,        32'h0,        1'b1, 0);
    txn(0, "sh_mis",     1'b1, F_H,  32'h11,   32'h0000AAAA, 32'h0,        1'b1, 0);
    txn(0, "lw_after_sh",1'b0, F_W,  32'h10,   32'h0,        32'hDEAD55EF, 1'b0, 0);
    txn(0, "f3_011",     1'b0, F_X,  32'h10,   32'h0,        32'h0,        1'b1, 0);
    txn(0, "lw_oor",     1'b0, F_W,  32'h1000, 32'h0,        32'h0,        1'b1, 0);
    txn(0, "sbu_illegal",1'b1, F_BU, 32'h10,   32'h000000FF, 32'h0,        1'b1, 0);
    txn(0, "lw_after_il",1'b0, F_W,  32'h10,   32'h0,        32'hDEAD55EF, 1'b0, 0);
    txn(0, "sh_12",      1'b1, F_H,  32'h12,   32'hFFFF1234, 32'h0,        1'b0, 0);
    txn(0, "lw_after_sh2",1'b0,F_W,  32'h10,   32'h0,        32'h123455EF, 1'b0, 0);
    txn(0, "sh_last",    1'b1, F_H,  32'hFFE,  32'h00008001, 32'h0,        1'b0, 0);
    txn(0, "lh_last",    1'b0, F_H,  32'hFFE,  32'h0,        32'hFFFF8001, 1'b0, 0);

    // Three wait states with backpressure
    txn(1, "w3_sw_40",   1'b1, F_W,  32'h40,   32'hA5A55A5A, 32'h0,        1'b0, 0);
    txn(1, "w3_lw_40",   1'b0, F_W,  32'h40,   32'h0,        32'hA5A55A5A, 1'b0, 5);

    // Reset during WAIT abandons the response but keeps the committed store
    @(negedge clk);
    req_we[1] = 1'b1; req_funct3[1] = F_W; req_addr[1] = 32'h20;
    req_wdata[1] = 32'h12345678; req_valid[1] = 1'b1;
    seen = 0;
    while (!req_ready[1] && seen < 50) begin
      @(negedge clk);
      seen++;
    end
    check("rst_accept_ready", 32'(req_ready[1]), 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid[1] = 1'b0;
    rst[1] = 1'b1;
    @(negedge clk);
    rst[1] = 1'b0;
    check("rst_mid_req_ready", 32'(req_ready[1]), 32'd0);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (rsp_valid[1]) seen++;
      @(negedge clk);
    end
    check("rst_mid_no_rsp", 32'(seen), 32'd0);
    txn(1, "w3_lw_20",   1'b0, F_W,  32'h20,   32'h0,        32'h12345678, 1'b0, 0);

    // Non-zero base address
    txn(2, "b8_sw_4",    1'b1, F_W,  32'h80000004, 32'hCAFEF00D, 32'h0,        1'b0, 0);
    txn(2, "b8_lw_4",    1'b0, F_W,  32'h80000004, 32'h0,        32'hCAFEF00D, 1'b0, 0);
    txn(2, "b8_lb_7",    1'b0, F_B,  32'h80000007, 32'h0,        32'hFFFFFFCA, 1'b0, 0);
    txn(2, "b8_below",   1'b0, F_W,  32'h7FFFFFFC, 32'h0,        32'h0,        1'b1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
